// File: rtl/m_vector_sequencer_if.sv
// rtl/m_vector_sequencer_if.sv - handshake and bus bundle for the m-vector sequencer
//
// Groups the pass control, the manager element channel, the weight bank write
// port and the result valid/ready channel.
//   slave  : the sequencer side (drives busy/done/request/result/protocol_error)
//   master : the surrounding logic (drives start/elements/weights/result_ready)
interface m_vector_sequencer_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        m_element_requested;
  logic        m_element_ready;
  logic [15:0] m_element;
  logic        weight_we;
  logic [2:0]  weight_addr;
  logic [15:0] weight_data;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result;
  logic [5:0]  result_index;
  logic        protocol_error;

  modport slave (
    input  start, m_element_ready, m_element, weight_we, weight_addr, weight_data,
           result_ready,
    output busy, done, m_element_requested, result_valid, result, result_index,
           protocol_error
  );

  modport master (
    output start, m_element_ready, m_element, weight_we, weight_addr, weight_data,
           result_ready,
    input  busy, done, m_element_requested, result_valid, result, result_index,
           protocol_error
  );
endinterface

// File: rtl/m_vector_sequencer.sv
// rtl/m_vector_sequencer.sv - per-group signed dot product sequencer for one filter pass
//
// For each of GROUPS groups: request a group from the m-vector manager, multiply
// the ELEMENTS returned elements with the weight bank, and present the 32-bit
// wrapped sum on a valid/ready channel tagged with its group number.
// Ports:
//   clock_i : rising-edge clock
//   clear_i : synchronous active-high reset (also zeroes the weight bank)
//   seq_if  : m_vector_sequencer_if.slave bundle (control, elements, weights, results)
module m_vector_sequencer #(
  parameter int GROUPS   = 64,
  parameter int ELEMENTS = 8
) (
  input  logic                  clock_i,
  input  logic                  clear_i,
  m_vector_sequencer_if.slave   seq_if
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_COLLECT = 3'd2;
  localparam logic [2:0] S_EMIT    = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  localparam logic [2:0] LAST_ELEM  = 3'(ELEMENTS - 1);
  localparam logic [5:0] LAST_GROUP = 6'(GROUPS - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [2:0]  elem_cnt_q, elem_cnt_d;
  logic [5:0]  group_q, group_d;
  logic [31:0] result_q, result_d;
  logic [5:0]  result_index_q, result_index_d;
  logic        perr_q, perr_d;
  logic signed [15:0] weight_q [8];

  logic signed [31:0] product;
  logic [31:0]        acc_sum;

  // Both operands signed, so they are sign-extended to 32 bits before the multiply.
  assign product = $signed(seq_if.m_element) * weight_q[elem_cnt_q];
  assign acc_sum = acc_q + product;

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    elem_cnt_d     = elem_cnt_q;
    group_d        = group_q;
    result_d       = result_q;
    result_index_d = result_index_q;
    perr_d         = perr_q;

    case (state_q)
      S_IDLE: begin
        if (seq_if.start) begin
          state_d    = S_REQ;
          acc_d      = '0;
          group_d    = '0;
          elem_cnt_d = '0;
          perr_d     = 1'b0;
        end
      end
      S_REQ: begin
        state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (seq_if.m_element_ready) begin
          acc_d      = acc_sum;
          elem_cnt_d = elem_cnt_q + 3'd1;
          if (elem_cnt_q == LAST_ELEM) begin
            result_d       = acc_sum;
            result_index_d = group_q;
            state_d        = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (seq_if.result_ready) begin
          acc_d      = '0;
          elem_cnt_d = '0;
          if (group_q == LAST_GROUP) begin
            state_d = S_FINISH;
          end else begin
            group_d = group_q + 6'd1;
            state_d = S_REQ;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An element arriving outside COLLECT is dropped and flagged; this wins
    // over the clear-on-start above when both happen on the same edge.
    if (seq_if.m_element_ready && (state_q != S_COLLECT)) begin
      perr_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      state_q        <= S_IDLE;
      acc_q          <= '0;
      elem_cnt_q     <= '0;
      group_q        <= '0;
      result_q       <= '0;
      result_index_q <= '0;
      perr_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      elem_cnt_q     <= elem_cnt_d;
      group_q        <= group_d;
      result_q       <= result_d;
      result_index_q <= result_index_d;
      perr_q         <= perr_d;
    end
  end

  // Weights are only writable between passes so a pass sees one consistent bank.
  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      for (int i = 0; i < 8; i++) begin
        weight_q[i] <= '0;
      end
    end else if (seq_if.weight_we && (state_q == S_IDLE)) begin
      weight_q[seq_if.weight_addr] <= seq_if.weight_data;
    end
  end

  assign seq_if.busy                = (state_q != S_IDLE);
  assign seq_if.done                = (state_q == S_FINISH);
  assign seq_if.m_element_requested = (state_q == S_REQ);
  assign seq_if.result_valid        = (state_q == S_EMIT);
  assign seq_if.result              = result_q;
  assign seq_if.result_index        = result_index_q;
  assign seq_if.protocol_error      = perr_q;

endmodule

// File: tb/tb_m_vector_sequencer.sv
// tb/tb_m_vector_sequencer.sv - self-checking bench for m_vector_sequencer
module tb_m_vector_sequencer;
  localparam int GROUPS = 64;

  logic clk = 1'b0;
  logic clear;
  int   total = 0;
  int   bad = 0;
  int   req_cnt = 0;
  int   done_cnt = 0;

  logic signed [15:0] elems   [GROUPS][8];
  logic signed [15:0] w_model [8];

  m_vector_sequencer_if sif ();

  m_vector_sequencer #(.GROUPS(GROUPS), .ELEMENTS(8)) dut (
    .clock_i (clk),
    .clear_i (clear),
    .seq_if  (sif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sif.m_element_requested === 1'b1) req_cnt++;
    if (sif.done === 1'b1) done_cnt++;
  end

  function automatic logic [31:0] model(input int g);
    longint s;
    s = 0;
    for (int k = 0; k < 8; k++) s += longint'(elems[g][k]) * longint'(w_model[k]);
    return s[31:0];
  endfunction

  task automatic write_weight(input int a, input logic [15:0] d);
    @(negedge clk);
    sif.weight_we   = 1'b1;
    sif.weight_addr = 3'(a);
    sif.weight_data = d;
    @(negedge clk);
    sif.weight_we = 1'b0;
    w_model[a] = d;
  endtask

  // mode 0: k+1, mode 1: constant c, mode 2: random
  task automatic fill_elems(input int mode, input logic [15:0] c);
    for (int g = 0; g < GROUPS; g++)
      for (int k = 0; k < 8; k++)
        elems[g][k] = (mode == 0) ? 16'(k + 1) : (mode == 1) ? c : 16'($urandom);
  endtask

  task automatic run_pass(input int max_gap, input bit tie_ready, input bit bp3,
                          input bit illegal, input int abort_group);
    int n;
    int req_base;
    int done_base;
    logic [31:0] exp;
    req_base = req_cnt;
    done_base = done_cnt;
    sif.result_ready = tie_ready;
    @(negedge clk);
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    total++;
    if (sif.busy !== 1'b1 || sif.m_element_requested !== 1'b1) begin
      bad++;
      $display("FAIL start_resp busy=%b req=%b required 1 1", sif.busy, sif.m_element_requested);
    end
    total++;
    if (sif.protocol_error !== 1'b0) begin
      bad++;
      $display("FAIL perr_clear_on_start got=%b required 0", sif.protocol_error);
    end
    for (int g = 0; g < GROUPS; g++) begin
      n = 0;
      while (sif.m_element_requested !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      total++;
      if (n >= 200) begin
        bad++;
        $display("FAIL req_timeout group=%0d", g);
        sif.result_ready = 1'b0;
        return;
      end
      @(negedge clk);
      total++;
      if (sif.m_element_requested !== 1'b0) begin
        bad++;
        $display("FAIL req_one_cycle group=%0d got=%b required 0", g, sif.m_element_requested);
      end
      exp = model(g);
      for (int k = 0; k < 8; k++) begin
        sif.m_element_ready = 1'b0;
        if (abort_group == g && k == 5) begin
          clear = 1'b1;
          @(negedge clk);
          clear = 1'b0;
          total++;
          if ({sif.busy, sif.done, sif.m_element_requested, sif.result_valid,
               sif.protocol_error} !== 5'b0 || sif.result !== 32'h0 || sif.result_index !== 6'h0) begin
            bad++;
            $display("FAIL clear_mid_pass flags=%b result=%h idx=%0d required all 0",
                     {sif.busy, sif.done, sif.m_element_requested, sif.result_valid,
                      sif.protocol_error}, sif.result, sif.result_index);
          end
          for (int i = 0; i < 8; i++) w_model[i] = '0;
          repeat (5) @(negedge clk);
          total++;
          if (sif.m_element_requested !== 1'b0 || sif.busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_clear req=%b busy=%b required 0 0",
                     sif.m_element_requested, sif.busy);
          end
          sif.result_ready = 1'b0;
          return;
        end
        if (illegal && g == 7 && k == 2) begin
          sif.start = 1'b1;
          @(negedge clk);
          sif.start = 1'b0;
        end
        if (illegal && g == 8 && k == 0) begin
          sif.weight_we   = 1'b1;
          sif.weight_addr = 3'd0;
          sif.weight_data = ~w_model[0];
          @(negedge clk);
          sif.weight_we = 1'b0;
        end
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
        sif.m_element_ready = 1'b1;
        sif.m_element = elems[g][k];
        @(negedge clk);
      end
      sif.m_element_ready = 1'b0;
      total++;
      if (sif.result_valid !== 1'b1 || sif.result !== exp || sif.result_index !== 6'(g)) begin
        bad++;
        $display("FAIL group_result group=%0d valid=%b result=%h idx=%0d required 1 %h %0d",
                 g, sif.result_valid, sif.result, sif.result_index, exp, g);
      end
      if (bp3 && g == 3) begin
        for (int i = 0; i < 10; i++) begin
          if (illegal && i == 2) begin
            sif.m_element_ready = 1'b1;
            sif.m_element = 16'h1234;
          end else begin
            sif.m_element_ready = 1'b0;
          end
          @(negedge clk);
          total++;
          if (sif.result_valid !== 1'b1 || sif.result !== exp || sif.result_index !== 6'd3 ||
              sif.m_element_requested !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_hold cyc=%0d valid=%b result=%h idx=%0d req=%b required 1 %h 3 0",
                     i, sif.result_valid, sif.result, sif.result_index, sif.m_element_requested, exp);
          end
        end
        sif.m_element_ready = 1'b0;
        if (illegal) begin
          total++;
          if (sif.protocol_error !== 1'b1) begin
            bad++;
            $display("FAIL perr_in_emit got=%b required 1", sif.protocol_error);
          end
        end
      end
      sif.result_ready = 1'b1;
      @(negedge clk);
      if (!tie_ready) sif.result_ready = 1'b0;
      total++;
      if (g < GROUPS - 1) begin
        if (sif.m_element_requested !== 1'b1) begin
          bad++;
          $display("FAIL next_req group=%0d got=%b required 1", g + 1, sif.m_element_requested);
        end
      end else if (sif.done !== 1'b1 || sif.busy !== 1'b1) begin
        bad++;
        $display("FAIL done_pulse done=%b busy=%b required 1 1", sif.done, sif.busy);
      end
    end
    @(negedge clk);
    total++;
    if (sif.busy !== 1'b0 || sif.done !== 1'b0) begin
      bad++;
      $display("FAIL pass_end busy=%b done=%b required 0 0", sif.busy, sif.done);
    end
    total++;
    if (req_cnt - req_base != GROUPS || done_cnt - done_base != 1) begin
      bad++;
      $display("FAIL pulse_counts req=%0d done=%0d required %0d 1",
               req_cnt - req_base, done_cnt - done_base, GROUPS);
    end
    if (illegal) begin
      total++;
      if (sif.protocol_error !== 1'b1) begin
        bad++;
        $display("FAIL perr_sticky got=%b required 1", sif.protocol_error);
      end
    end
    sif.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    sif.start = 1'b0;
    sif.m_element_ready = 1'b0;
    sif.m_element = '0;
    sif.weight_we = 1'b0;
    sif.weight_addr = '0;
    sif.weight_data = '0;
    sif.result_ready = 1'b0;
    for (int i = 0; i < 8; i++) w_model[i] = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({sif.busy, sif.done, sif.m_element_requested, sif.result_valid,
         sif.protocol_error} !== 5'b0 || sif.result !== 32'h0 || sif.result_index !== 6'h0) begin
      bad++;
      $display("FAIL reset_values flags=%b result=%h idx=%0d required all 0",
               {sif.busy, sif.done, sif.m_element_requested, sif.result_valid,
                sif.protocol_error}, sif.result, sif.result_index);
    end
    clear = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) write_weight(i, 16'd1);
    fill_elems(0, 16'h0);
    total++;
    if (model(0) !== 32'd36) begin
      bad++;
      $display("FAIL basic_model got=%0d required 36", model(0));
    end
    run_pass(0, 1'b1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_signed_wrap();
    write_weight(0, 16'h8000);
    for (int i = 1; i < 8; i++) write_weight(i, 16'h0);
    fill_elems(1, 16'h8000);
    total++;
    if (model(5) !== 32'h4000_0000) begin
      bad++;
      $display("FAIL signed_model got=%h required 40000000", model(5));
    end
    run_pass(2, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 8; i++) write_weight(i, 16'h7FFF);
    fill_elems(1, 16'h7FFF);
    total++;
    if (model(5) !== 32'hFFF8_0008) begin
      bad++;
      $display("FAIL wrap_model got=%h required fff80008", model(5));
    end
    run_pass(1, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) write_weight(i, 16'($urandom));
    fill_elems(2, 16'h0);
    run_pass(3, 1'b0, 1'b1, 1'b0, -1);
  endtask

  task automatic test_illegal();
    @(negedge clk);
    sif.m_element_ready = 1'b1;
    sif.m_element = 16'h7777;
    @(negedge clk);
    sif.m_element_ready = 1'b0;
    total++;
    if (sif.protocol_error !== 1'b1 || sif.busy !== 1'b0) begin
      bad++;
      $display("FAIL perr_in_idle perr=%b busy=%b required 1 0", sif.protocol_error, sif.busy);
    end
    fill_elems(2, 16'h0);
    run_pass(3, 1'b0, 1'b1, 1'b1, -1);
  endtask

  task automatic test_reset_mid();
    fill_elems(2, 16'h0);
    run_pass(2, 1'b0, 1'b0, 1'b0, 10);
    fill_elems(2, 16'h0);
    run_pass(1, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_irregular();
    for (int i = 0; i < 8; i++) write_weight(i, 16'($urandom));
    fill_elems(2, 16'h0);
    run_pass(20, 1'b0, 1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed_wrap();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_irregular();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/m_vector_sequencer.md
# m_vector_sequencer

Sequences the m-vector fetch datapath for one full filter pass. It issues one `m_element_requested` pulse per group of 8 elements, 64 groups per pass, and forms the signed dot product of each group with an 8-entry filter weight bank. Each 32-bit result is emitted over a valid/ready handshake. The block sits between the m-vector manager (element source) and the downstream activation/accumulation stage.

## Interface
- `GROUPS`, 64: groups per pass; must be ≥1 and ≤64. The result index is 6 bits.
- `ELEMENTS`, 8: elements per group; fixed to match the manager's 3-bit filter index.
- `clock` in 1: single clock; all state changes on its rising edge.
- `clear` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a pass; ignored while `busy`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the pass completes.
- `m_element_requested` out 1: one-cycle request to the manager for the next group.
- `m_element_ready` in 1: one pulse per returned element.
- `m_element` in 16: signed element data, valid while `m_element_ready` is high.
- `weight_we` in 1: write strobe for the weight bank.
- `weight_addr` in 3: weight bank index.
- `weight_data` in 16: signed weight value.
- `result_valid` out 1: a result is presented.
- `result_ready` in 1: downstream accepts the result.
- `result` out 32: signed dot product for the group.
- `result_index` out 6: group number of the presented result (0..GROUPS-1).
- `protocol_error` out 1: sticky flag for an unexpected `m_element_ready`.

## Operation
- States: IDLE, REQ, COLLECT, EMIT, FINISH.
- IDLE → REQ on `start`. On the same edge, clear the accumulator, `group`=0, `elem_cnt`=0 and `protocol_error`.
- REQ: `m_element_requested`=1 for exactly one cycle, then → COLLECT.
- COLLECT: on each `m_element_ready`:
  - `acc <= acc + sext32(m_element) * sext32(weight[elem_cnt])`, then `elem_cnt++`.
  - On the 8th accepted element, the updated sum is loaded into `result`, `result_index`=`group`, and the state → EMIT.
- EMIT: hold `result_valid`=1 with a stable `result`/`result_index` until `result_ready`. On that handshake edge:
  - clear `acc` and `elem_cnt`;
  - if `group`==GROUPS-1 → FINISH, else increment `group` and → REQ.
- FINISH: `done`=1 for one cycle, → IDLE.
- Arithmetic:
  - Product is a full signed 16×16→32.
  - Accumulation wraps modulo 2^32 with no saturation (e.g. 0x7FFF·0x7FFF·8 wraps).
- Weights:
  - A write with `weight_we` is accepted only while not `busy`; writes while `busy` are dropped.
  - Weights persist across passes. `clear` zeroes all 8 weights.
- `m_element_ready` outside COLLECT:
  - The element is discarded and `protocol_error` is set.
  - `protocol_error` clears only on `clear` or an accepted `start`.
- `start` while `busy`: ignored, no effect.
- `clear` mid-pass: the next edge returns to IDLE with all outputs at reset values. No further request is issued, and an in-flight result is dropped.

## Timing
- Reset values: `busy`, `done`, `m_element_requested`, `result_valid` and `protocol_error` are 0; `result` and `result_index` are 0.
- `start` sampled at edge t: `busy` and `m_element_requested` are high in cycle t+1, and `m_element_requested` is low at t+2.
- Manager return latency is arbitrary; COLLECT waits indefinitely. Back-to-back `m_element_ready` pulses are accepted every cycle.
- `result_valid` rises the cycle after the edge that accepts the 8th element.
- After the result handshake at edge h:
  - next group: `m_element_requested` is high in cycle h+1;
  - last group: `done` is high in cycle h+1, and `busy` falls at h+2.
- `result_ready` is ignored while `result_valid`=0.
- At most one group is outstanding at the manager at any time.

## Test plan
- **Basic pass:** weights all 1, elements k=1..8 per group, `result_ready` tied 1. Expect 64 results each equal to 36, `result_index` 0..63 in order, one `done` pulse, and exactly 64 `m_element_requested` pulses.
- **Signed and wrap:** weight[0]=0x8000, others 0, every element[0]=0x8000. Expect `result`=0x40000000. Then set all weights and elements to 0x7FFF; expect 8·0x3FFF0001 mod 2^32 = 0xFFF80008.
- **Backpressure:** hold `result_ready`=0 for 10 cycles on group 3. Expect `result` and `result_index`=3 stable, no new `m_element_requested` until the handshake, then the group 4 request the next cycle.
- **Illegal events:** `m_element_ready` in IDLE or EMIT → `protocol_error`=1 and the accumulator is unchanged. A `weight_we` while `busy` is dropped (readback via the next pass result). A second `start` mid-pass is ignored.
- **Reset mid-operation:** assert `clear` after 5 elements of group 10. Expect all outputs at reset values next cycle and weights zeroed. A fresh `start` yields results from group 0.
- **Irregular latency:** random 0–20 cycle gaps between `m_element_ready` pulses and before the first element. Results must match a reference model for all 64 groups.
